load_store_unit: RTL and testbench

//   Sits between the core's execute stage and DataMem. Accepts one load/store request per

---
 rtl/load_store_unit_pkg.sv | 31 +++
 rtl/load_store_unit_if.sv | 26 ++
 rtl/lsu_access_check.sv | 35 +++
 rtl/load_store_unit.sv | 143 ++++++++++++++
 tb/tb_load_store_unit.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 codes and the
// extension helper used for split loads.
package load_store_unit_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;

  typedef enum logic [2:0] {
    StIdle,
    StSingle,
    StSplit,
    StResp,
    StErr
  } lsu_state_e;

  localparam logic [2:0] F3Byte  = 3'd0;
  localparam logic [2:0] F3Half  = 3'd1;
  localparam logic [2:0] F3Word  = 3'd2;
  localparam logic [2:0] F3ByteU = 3'd4;
  localparam logic [2:0] F3HalfU = 3'd5;

  // Split accesses are only ever half or word, so byte codes fall through to the raw buffer.
  function automatic logic [31:0] extend_split(input logic [2:0] func3, input logic [31:0] data);
    case (func3)
      F3Half:  return {{16{data[15]}}, data[15:0]};
      F3HalfU: return {16'b0, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake between the execute stage (master) and the load/store unit.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [2:0]           req_func3;
  logic [AddrWidth-1:0] req_addr;
  logic [DataWidth-1:0] req_wdata;
  logic [AddrWidth-1:0] req_pc;
  logic                 resp_valid;
  logic                 resp_error;
  logic [DataWidth-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_func3, req_addr, req_wdata, req_pc,
    input  req_ready, resp_valid, resp_error, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_func3, req_addr, req_wdata, req_pc,
    output req_ready, resp_valid, resp_error, resp_rdata
  );

endinterface

// File: rtl/lsu_access_check.sv
// Classifies a load/store request: funct3 legality, natural alignment and access size.
module lsu_access_check
  import load_store_unit_pkg::*;
(
  input  logic       write_i,
  input  logic [2:0] func3_i,
  input  logic [1:0] addr_lo_i,
  output logic       legal_o,
  output logic       aligned_o,
  output logic [2:0] n_bytes_o
);

  always_comb begin
    legal_o   = 1'b0;
    aligned_o = 1'b1;
    n_bytes_o = 3'd1;
    case (func3_i)
      F3Byte, F3Half, F3Word: legal_o = 1'b1;
      F3ByteU, F3HalfU:       legal_o = !write_i;
      default:                legal_o = 1'b0;
    endcase
    case (func3_i[1:0])
      2'd1: begin
        aligned_o = !addr_lo_i[0];
        n_bytes_o = 3'd2;
      end
      2'd2: begin
        aligned_o = (addr_lo_i == 2'b00);
        n_bytes_o = 3'd4;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: issues aligned accesses directly and breaks misaligned half/word accesses
// into ascending byte accesses, reassembling and extending load data.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter bit MisalignEn = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  load_store_unit_if.slave     core_io,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [2:0]           mem_func3_o,
  output logic                 mem_write_enable_o,
  output logic [DataWidth-1:0] mem_write_data_o,
  output logic [AddrWidth-1:0] mem_pc_o,
  input  logic [DataWidth-1:0] mem_read_data_i
);

  lsu_state_e           state_q, state_d;
  logic                 write_q, write_d;
  logic [2:0]           func3_q, func3_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [AddrWidth-1:0] pc_q, pc_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [1:0]           last_idx_q, last_idx_d;
  logic [DataWidth-1:0] buf_q, buf_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;

  logic       legal, aligned;
  logic [2:0] n_bytes;

  lsu_access_check u_check (
    .write_i   (core_io.req_write),
    .func3_i   (core_io.req_func3),
    .addr_lo_i (core_io.req_addr[1:0]),
    .legal_o   (legal),
    .aligned_o (aligned),
    .n_bytes_o (n_bytes)
  );

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    func3_d    = func3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    pc_d       = pc_q;
    byte_idx_d = byte_idx_q;
    last_idx_d = last_idx_q;
    buf_d      = buf_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (core_io.req_valid) begin
          write_d    = core_io.req_write;
          func3_d    = core_io.req_func3;
          addr_d     = core_io.req_addr;
          wdata_d    = core_io.req_wdata;
          pc_d       = core_io.req_pc;
          byte_idx_d = 2'd0;
          last_idx_d = 2'(n_bytes - 3'd1);
          buf_d      = '0;
          rdata_d    = '0;
          if (!legal || (!aligned && !MisalignEn)) begin
            state_d = StErr;
          end else if (aligned) begin
            state_d = StSingle;
          end else begin
            state_d = StSplit;
          end
        end
      end
      StSingle: begin
        if (!write_q) rdata_d = mem_read_data_i;
        state_d = StResp;
      end
      StSplit: begin
        if (!write_q) buf_d[{byte_idx_q, 3'b000} +: 8] = mem_read_data_i[7:0];
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == last_idx_q) begin
          // Extend from buf_d so the final byte fetched this cycle is included.
          if (!write_q) rdata_d = extend_split(func3_q, buf_d);
          state_d = StResp;
        end
      end
      StResp, StErr: state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  always_comb begin
    core_io.req_ready  = (state_q == StIdle);
    core_io.resp_valid = (state_q == StResp) || (state_q == StErr);
    core_io.resp_error = (state_q == StErr);
    core_io.resp_rdata = (state_q == StResp) ? rdata_q : '0;
    mem_addr_o         = '0;
    mem_func3_o        = 3'd0;
    mem_write_enable_o = 1'b0;
    mem_write_data_o   = '0;
    mem_pc_o           = '0;
    if (state_q == StSingle) begin
      mem_addr_o         = addr_q;
      mem_func3_o        = func3_q;
      mem_write_enable_o = write_q;
      mem_write_data_o   = wdata_q;
      mem_pc_o           = pc_q;
    end else if (state_q == StSplit) begin
      mem_addr_o         = addr_q + AddrWidth'(byte_idx_q);
      mem_func3_o        = write_q ? F3Byte : F3ByteU;
      mem_write_enable_o = write_q;
      mem_write_data_o   = {24'b0, wdata_q[{byte_idx_q, 3'b000} +: 8]};
      mem_pc_o           = pc_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      func3_q    <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      pc_q       <= '0;
      byte_idx_q <= 2'd0;
      last_idx_q <= 2'd0;
      buf_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      func3_q    <= func3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      pc_q       <= pc_d;
      byte_idx_q <= byte_idx_d;
      last_idx_q <= last_idx_d;
      buf_q      <= buf_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: LSU paired with a byte-array DataMem model, plus a second LSU built with
// misaligned splitting disabled.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if core_if ();
  load_store_unit_if core0_if ();

  logic [31:0] mem_addr, mem_wdata, mem_pc, mem_rdata;
  logic [2:0]  mem_f3;
  logic        mem_we;
  logic [31:0] mem0_addr, mem0_wdata, mem0_pc;
  logic [2:0]  mem0_f3;
  logic        mem0_we;

  load_store_unit #(.MisalignEn(1'b1)) u_dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .core_io            (core_if),
    .mem_addr_o         (mem_addr),
    .mem_func3_o        (mem_f3),
    .mem_write_enable_o (mem_we),
    .mem_write_data_o   (mem_wdata),
    .mem_pc_o           (mem_pc),
    .mem_read_data_i    (mem_rdata)
  );

  load_store_unit #(.MisalignEn(1'b0)) u_dut0 (
    .clk_i              (clk),
    .rst_i              (rst),
    .core_io            (core0_if),
    .mem_addr_o         (mem0_addr),
    .mem_func3_o        (mem0_f3),
    .mem_write_enable_o (mem0_we),
    .mem_write_data_o   (mem0_wdata),
    .mem_pc_o           (mem0_pc),
    .mem_read_data_i    (32'h0)
  );

  // DataMem model: aligned-only, combinational read with extension, write on posedge.
  bit [7:0] mem [4096];
  logic [11:0] ma;
  logic [31:0] mword;
  assign ma    = mem_addr[11:0];
  assign mword = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};

  always_comb begin
    mem_rdata = 32'h0;
    case (mem_f3)
      3'd0: mem_rdata = {{24{mword[7]}}, mword[7:0]};
      3'd1: mem_rdata = {{16{mword[15]}}, mword[15:0]};
      3'd2: mem_rdata = mword;
      3'd4: mem_rdata = {24'h0, mword[7:0]};
      3'd5: mem_rdata = {16'h0, mword[15:0]};
      default: mem_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      mem[ma] <= mem_wdata[7:0];
      if (mem_f3[1:0] != 2'd0) mem[ma + 12'd1] <= mem_wdata[15:8];
      if (mem_f3[1:0] == 2'd2) begin
        mem[ma + 12'd2] <= mem_wdata[23:16];
        mem[ma + 12'd3] <= mem_wdata[31:24];
      end
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] pc;
  } acc_t;

  acc_t log_q[$];
  int   we_cnt = 0;
  int   we0_cnt = 0;
  int   pc0_cnt = 0;

  // Every cycle with a nonzero memPC is one memory transaction.
  always @(negedge clk) begin
    if (mem_pc != 32'h0) log_q.push_back('{mem_addr, mem_f3, mem_we, mem_wdata, mem_pc});
    if (mem_we) we_cnt++;
    if (mem0_we) we0_cnt++;
    if (mem0_pc != 32'h0) pc0_cnt++;
  end

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nacc;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          lat;
    int          start;
    int          we_start;
    logic        er;
    logic [31:0] rd;
    logic [31:0] pc;
    bit          split;
    lat = 0;
    er  = 1'b0;
    rd  = 32'h0;
    pc  = 32'h1000 + 32'(idx) * 32'd4;
    @(negedge clk);
    chk($sformatf("v%0d ready", idx), 32'(core_if.req_ready), 32'd1);
    start    = log_q.size();
    we_start = we_cnt;
    core_if.req_valid = 1'b1;
    core_if.req_write = v.wr;
    core_if.req_func3 = v.f3;
    core_if.req_addr  = v.addr;
    core_if.req_wdata = v.wdata;
    core_if.req_pc    = pc;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) core_if.req_valid = 1'b0;
      if (core_if.resp_valid) begin
        lat = c;
        er  = core_if.resp_error;
        rd  = core_if.resp_rdata;
        break;
      end
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d error", idx), 32'(er), 32'(v.err));
    chk($sformatf("v%0d rdata", idx), rd, v.rdata);
    @(negedge clk);
    chk($sformatf("v%0d resp one cycle", idx), 32'(core_if.resp_valid), 32'd0);
    chk($sformatf("v%0d n accesses", idx), 32'(log_q.size() - start), 32'(v.nacc));
    chk($sformatf("v%0d we cycles", idx), 32'(we_cnt - we_start),
        (v.wr && !v.err) ? 32'(v.nacc) : 32'd0);
    split = (v.nacc > 1);
    for (int i = 0; i < v.nacc && (start + i) < log_q.size(); i++) begin
      acc_t a;
      a = log_q[start + i];
      chk($sformatf("v%0d acc%0d addr", idx, i), a.addr, split ? v.addr + 32'(i) : v.addr);
      chk($sformatf("v%0d acc%0d func3", idx, i), 32'(a.f3),
          split ? (v.wr ? 32'd0 : 32'd4) : 32'(v.f3));
      chk($sformatf("v%0d acc%0d wdata", idx, i), a.wdata,
          split ? {24'h0, v.wdata[8*i +: 8]} : v.wdata);
      chk($sformatf("v%0d acc%0d pc", idx, i), a.pc, pc);
    end
  endtask

  vec_t vecs[16];
  int   lat0;
  int   resp_cnt;
  logic err0;
  logic [31:0] rd0;

  initial begin
    vecs[0]  = '{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,        2, 1};
    vecs[1]  = '{1'b0, 3'd2, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF, 2, 1};
    vecs[2]  = '{1'b1, 3'd2, 32'h101, 32'h11223344, 1'b0, 32'h0,        5, 4};
    vecs[3]  = '{1'b0, 3'd2, 32'h101, 32'h0,        1'b0, 32'h11223344, 5, 4};
    vecs[4]  = '{1'b1, 3'd1, 32'h203, 32'h000080FF, 1'b0, 32'h0,        3, 2};
    vecs[5]  = '{1'b0, 3'd1, 32'h203, 32'h0,        1'b0, 32'hFFFF80FF, 3, 2};
    vecs[6]  = '{1'b0, 3'd5, 32'h203, 32'h0,        1'b0, 32'h000080FF, 3, 2};
    vecs[7]  = '{1'b0, 3'd3, 32'h100, 32'h0,        1'b1, 32'h0,        1, 0};
    vecs[8]  = '{1'b1, 3'd4, 32'h010, 32'hCAFEF00D, 1'b1, 32'h0,        1, 0};
    vecs[9]  = '{1'b0, 3'd2, 32'h002, 32'h0,        1'b0, 32'h0,        5, 4};
    vecs[10] = '{1'b0, 3'd0, 32'h102, 32'h0,        1'b0, 32'h00000033, 2, 1};
    vecs[11] = '{1'b0, 3'd0, 32'h203, 32'h0,        1'b0, 32'hFFFFFFFF, 2, 1};
    vecs[12] = '{1'b0, 3'd4, 32'h203, 32'h0,        1'b0, 32'h000000FF, 2, 1};
    vecs[13] = '{1'b0, 3'd1, 32'h102, 32'h0,        1'b0, 32'h00002233, 2, 1};
    vecs[14] = '{1'b0, 3'd1, 32'h101, 32'h0,        1'b0, 32'h00003344, 3, 2};
    vecs[15] = '{1'b1, 3'd1, 32'h010, 32'h00001234, 1'b0, 32'h0,        2, 1};

    core_if.req_valid  = 1'b0;
    core_if.req_write  = 1'b0;
    core_if.req_func3  = 3'd0;
    core_if.req_addr   = 32'h0;
    core_if.req_wdata  = 32'h0;
    core_if.req_pc     = 32'h0;
    core0_if.req_valid = 1'b0;
    core0_if.req_write = 1'b0;
    core0_if.req_func3 = 3'd0;
    core0_if.req_addr  = 32'h0;
    core0_if.req_wdata = 32'h0;
    core0_if.req_pc    = 32'h0;

    #2;
    chk("reset ready", 32'(core_if.req_ready), 32'd1);
    chk("reset resp_valid", 32'(core_if.resp_valid), 32'd0);
    chk("reset resp_error", 32'(core_if.resp_error), 32'd0);
    chk("reset rdata", core_if.resp_rdata, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_pc", mem_pc, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    chk("byte 0x101", 32'(mem[12'h101]), 32'h44);
    chk("byte 0x102", 32'(mem[12'h102]), 32'h33);
    chk("byte 0x103", 32'(mem[12'h103]), 32'h22);
    chk("byte 0x104", 32'(mem[12'h104]), 32'h11);
    chk("byte 0x203", 32'(mem[12'h203]), 32'hFF);
    chk("byte 0x204", 32'(mem[12'h204]), 32'h80);
    chk("byte 0x010", 32'(mem[12'h010]), 32'h34);
    chk("byte 0x011", 32'(mem[12'h011]), 32'h12);

    // Splitting disabled: misaligned lw is rejected without touching memory.
    @(negedge clk);
    core0_if.req_valid = 1'b1;
    core0_if.req_func3 = 3'd2;
    core0_if.req_addr  = 32'h2;
    core0_if.req_pc    = 32'h2000;
    @(posedge clk);
    lat0 = 0;
    err0 = 1'b0;
    rd0  = 32'hFFFFFFFF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) core0_if.req_valid = 1'b0;
      if (core0_if.resp_valid) begin
        lat0 = c;
        err0 = core0_if.resp_error;
        rd0  = core0_if.resp_rdata;
        break;
      end
    end
    chk("noSplit latency", 32'(lat0), 32'd1);
    chk("noSplit error", 32'(err0), 32'd1);
    chk("noSplit rdata", rd0, 32'h0);
    @(negedge clk);
    chk("noSplit we cycles", 32'(we0_cnt), 32'd0);
    chk("noSplit accesses", 32'(pc0_cnt), 32'd0);

    // Reset while byte 2 of a split sw is on the bus.
    @(negedge clk);
    core_if.req_valid = 1'b1;
    core_if.req_write = 1'b1;
    core_if.req_func3 = 3'd2;
    core_if.req_addr  = 32'h301;
    core_if.req_wdata = 32'hA1B2C3D4;
    core_if.req_pc    = 32'h3000;
    @(posedge clk);
    @(negedge clk);
    core_if.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst-split byte2 addr", mem_addr, 32'h303);
    rst = 1'b1;
    #1;
    chk("rst-split ready", 32'(core_if.req_ready), 32'd1);
    chk("rst-split mem_we", 32'(mem_we), 32'd0);
    chk("rst-split mem_addr", mem_addr, 32'h0);
    chk("rst-split mem_pc", mem_pc, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    resp_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (core_if.resp_valid) resp_cnt++;
    end
    chk("rst-split no resp", 32'(resp_cnt), 32'd0);
    chk("rst-split ready after", 32'(core_if.req_ready), 32'd1);
    chk("rst-split byte 0x301", 32'(mem[12'h301]), 32'hD4);
    chk("rst-split byte 0x302", 32'(mem[12'h302]), 32'hC3);
    chk("rst-split byte 0x303", 32'(mem[12'h303]), 32'h00);
    chk("rst-split byte 0x304", 32'(mem[12'h304]), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
